// File: rtl/alu_corr_pkg.sv
// Shared definitions for the approximate ALU correction stage:
// op codes, controller state encoding and the per-op correction step count.
package alu_corr_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_MUL = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of CORR cycles an op needs; ops without correction return 0.
    function automatic int unsigned corr_steps(input logic [2:0] op, input int unsigned k);
        case (op)
            OP_ADD:  return 1;
            OP_MUL:  return k;
            default: return 0;
        endcase
    endfunction

    // Only ADD and MUL are approximated, so only they enter CORR.
    function automatic logic op_is_approx(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/approx_alu_core.sv
// Combinational approximate ALU: lower-part-OR adder and truncated-LSB
// multiplier; logic ops are exact, reserved op codes give zero.
module approx_alu_core
    import alu_corr_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     op,
    output logic [2*W-1:0] y
);

    localparam logic [W-1:0] MK = W'((1 << K) - 1);

    logic [W:0]     hi_sum;
    logic [W:0]     add_res;
    logic [2*W-1:0] mul_res;

    // High parts add normally; low K bits are OR-ed with no carry into the high part.
    always_comb begin
        hi_sum  = (W+1)'(a >> K) + (W+1)'(b >> K);
        add_res = (hi_sum << K) | {1'b0, (a | b) & MK};
        mul_res = (2*W)'(a & ~MK) * (2*W)'(b & ~MK);
    end

    // Result select, zero-extended to 2W bits.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = {{(W-1){1'b0}}, add_res};
            OP_MUL:  y = mul_res;
            OP_AND:  y = {{W{1'b0}}, a & b};
            OP_OR:   y = {{W{1'b0}}, a | b};
            OP_XOR:  y = {{W{1'b0}}, a ^ b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/approx_alu_corrector.sv
// Error-correcting wrapper around approx_alu_core. Captures operands on a
// valid/ready handshake, loads the approximate result, optionally walks a
// fixed-length exact correction sequence, and holds the result until taken.
module approx_alu_corrector
    import alu_corr_pkg::*;
#(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     op,
    input  logic           corr_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] y,
    output logic           corrected,
    output logic           busy
);

    if (K < 1 || K > W - 1) begin : g_bad_k
        $error("approx_alu_corrector: K must lie in 1..W-1");
    end

    localparam int           CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0] MK = W'((1 << K) - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q;
    logic [2:0]     op_q;
    logic           en_q;
    logic [2*W-1:0] acc_q, acc_d;
    logic           corr_q, corr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2*W-1:0] approx_y;
    logic [2*W-1:0] term_a, term_b, addend;
    logic [CW-1:0]  last_step;
    logic           accept;

    approx_alu_core #(
        .W (W),
        .K (K)
    ) u_core (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (approx_y)
    );

    assign accept    = in_valid && (state_q == IDLE);
    assign last_step = CW'(corr_steps(op_q, K) - 1);

    // Correction addend for the current step: low-part carry for ADD,
    // one partial-product row pair (al*b and ah*bl) per step for MUL.
    always_comb begin
        term_a = '0;
        term_b = '0;
        if (a_q[cnt_q]) term_a = {{W{1'b0}}, b_q} << cnt_q;
        if (b_q[cnt_q]) term_b = {{W{1'b0}}, a_q & ~MK} << cnt_q;
        if (op_q == OP_ADD) addend = {{W{1'b0}}, a_q & b_q & MK};
        else                addend = term_a + term_b;
    end

    // Next-state and datapath update for the controller.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        corr_d  = corr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                acc_d   = approx_y;
                corr_d  = 1'b0;
                cnt_d   = '0;
                state_d = (en_q && op_is_approx(op_q)) ? CORR : DONE;
            end
            CORR: begin
                acc_d = acc_q + addend;
                if (addend != '0) corr_d = 1'b1;
                if (cnt_q == last_step) state_d = DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, accumulator, sticky flag and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            corr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            corr_q  <= corr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand capture on the input handshake only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= OP_ADD;
            en_q <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            en_q <= corr_en;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign y         = acc_q;
    assign corrected = corr_q;

endmodule

// File: tb/tb_approx_alu_corrector.sv
// Scoreboard bench for approx_alu_corrector (W=16, K=4): directed vectors
// push expected results; a monitor pops and checks on each output handshake.
module tb_approx_alu_corrector;

    localparam int W = 16;
    localparam int K = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [2:0]    op = 3'b000;
    logic          corr_en = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] y;
    logic          corrected;
    logic          busy;

    typedef struct {
        logic [31:0] y;
        logic        c;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_v = 0;
    bit   seen_v = 0;
    int   valid_seen_cnt = 0;

    approx_alu_corrector #(.W(W), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .corr_en   (corr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .corrected (corrected),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on each output handshake, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_v = 0;
        end else if (out_valid) begin
            valid_seen_cnt++;
            if (!seen_v) begin
                seen_v  = 1;
                first_v = cyc;
            end
            if (out_ready) begin
                seen_v = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got y=0x%0h with no outstanding request", y);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("y", 64'(y), 64'(e.y));
                    chk("corrected", 64'(corrected), 64'(e.c));
                    chk("latency", 64'(first_v - e.cyc), 64'(e.lat));
                end
            end
        end
    end

    // Drive one request (called at posedge+1); returns after the accept edge.
    task automatic send(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic en, input logic [31:0] ey, input logic ec, input int el,
                        input bit expect_out);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
            return;
        end
        a = aa; b = bb; op = o; corr_en = en; in_valid = 1'b1;
        if (expect_out) begin
            e.y = ey; e.c = ec; e.lat = el; e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state while reset is asserted and just after release
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_corrected", 64'(corrected), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(3'b000, 16'h0003, 16'h0003, 1'b1, 32'h0000_0006, 1'b1, 3, 1);
        send(3'b000, 16'h0003, 16'h0003, 1'b0, 32'h0000_0003, 1'b0, 2, 1);

        // MUL: approximate product visible in the accumulator right after LOAD
        send(3'b001, 16'h0013, 16'h0011, 1'b1, 32'h0000_0143, 1'b1, 6, 1);
        @(posedge clk); #1;
        chk("mul_acc_after_load", 64'(y), 64'h100);
        chk("mul_busy_in_corr", 64'(busy), 64'd1);

        send(3'b001, 16'h00F0, 16'h0020, 1'b1, 32'h0000_1E00, 1'b0, 6, 1);
        send(3'b000, 16'hFFFF, 16'h0001, 1'b1, 32'h0001_0000, 1'b1, 3, 1);
        send(3'b100, 16'hA5A5, 16'h0FF0, 1'b1, 32'h0000_AA55, 1'b0, 2, 1);
        send(3'b111, 16'h1234, 16'h5678, 1'b1, 32'h0000_0000, 1'b0, 2, 1);
        send(3'b001, 16'h0013, 16'h0011, 1'b0, 32'h0000_0100, 1'b0, 2, 1);
        send(3'b010, 16'hF0F0, 16'hFF00, 1'b1, 32'h0000_F000, 1'b0, 2, 1);
        send(3'b011, 16'hF0F0, 16'h0FF0, 1'b1, 32'h0000_FFF0, 1'b0, 2, 1);
        send(3'b001, 16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE_0001, 1'b1, 6, 1);
        send(3'b000, 16'h0010, 16'h0005, 1'b1, 32'h0000_0015, 1'b0, 3, 1);

        // Backpressure: hold DONE for 5 cycles while in_valid pulses are ignored
        n = 0;
        while (in_ready == 1'b0 && n < 50) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        send(3'b000, 16'h0003, 16'h0003, 1'b1, 32'h0000_0006, 1'b1, 3, 1);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a = 16'h7777; b = 16'h1111; op = 3'b001; corr_en = 1'b1;
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_y", 64'(y), 64'h6);
            chk("bp_corrected", 64'(corrected), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", 64'(in_ready), 64'd1);

        // Reset during the second MUL CORR cycle discards the operation
        send(3'b001, 16'h0013, 16'h0011, 1'b1, 32'h0, 1'b0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_y", 64'(y), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        valid_seen_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_output", 64'(valid_seen_cnt), 64'd0);

        // Drain the scoreboard with a bounded wait
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
